// File: rtl/cpht_choice_table.sv
// Choice-predictor history table: ENTRIES saturating counters choosing between
// predictor 1 and predictor 2, with a registered lookup port, an update port and a GHR.
module cpht_choice_table #(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned GHR_W     = 6,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned HASH_MODE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lk_valid,
    input  logic [PC_W-1:0]    lk_pc,
    output logic               sel_valid,
    output logic               sel_p2,
    output logic               sel_strong,
    output logic [IDX_W-1:0]   sel_idx,
    input  logic               upd_valid,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic               upd_p1_res,
    input  logic               upd_p2_res,
    input  logic               ghr_push,
    input  logic               ghr_taken,
    input  logic               ghr_restore,
    input  logic [GHR_W-1:0]   ghr_restore_val,
    output logic [GHR_W-1:0]   ghr
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_d;
    logic [CTR_W-1:0] lk_ctr;
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [GHR_W-1:0] ghr_shift;
    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] lk_idx;
    logic             sel_valid_q;
    logic             sel_p2_q;
    logic             sel_strong_q;
    logic [IDX_W-1:0] sel_idx_q;
    logic             unused_pc;

    assign unused_pc = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0]};

    generate
        if (GHR_W == 1) begin : g_ghr1
            assign ghr_shift = ghr_taken;
        end else begin : g_ghrn
            assign ghr_shift = {ghr_q[GHR_W-2:0], ghr_taken};
        end
    endgenerate

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr_q;
        if (HASH_MODE == 1) begin
            lk_idx = lk_pc[IDX_W+1:2] ^ ghr_ext;
        end else begin
            lk_idx = lk_pc[IDX_W+1:2];
        end
    end

    always_comb begin
        ctr_cur = ctr_q[upd_idx];
        ctr_d   = ctr_cur;
        if (upd_p2_res && !upd_p1_res && ctr_cur != CTR_MAX) begin
            ctr_d = ctr_cur + CTR_W'(1);
        end else if (upd_p1_res && !upd_p2_res && ctr_cur != '0) begin
            ctr_d = ctr_cur - CTR_W'(1);
        end
    end

    // A same-cycle update to the looked-up entry is forwarded so the lookup sees it.
    always_comb begin
        if (upd_valid && upd_idx == lk_idx) begin
            lk_ctr = ctr_d;
        end else begin
            lk_ctr = ctr_q[lk_idx];
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (ghr_restore) begin
            ghr_d = ghr_restore_val;
        end else if (ghr_push) begin
            ghr_d = ghr_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else if (upd_valid) begin
            ctr_q[upd_idx] <= ctr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q        <= '0;
            sel_valid_q  <= 1'b0;
            sel_p2_q     <= 1'b0;
            sel_strong_q <= 1'b0;
            sel_idx_q    <= '0;
        end else begin
            ghr_q       <= ghr_d;
            sel_valid_q <= lk_valid;
            if (lk_valid) begin
                sel_p2_q     <= lk_ctr[CTR_W-1];
                sel_strong_q <= (lk_ctr == '0) || (lk_ctr == CTR_MAX);
                sel_idx_q    <= lk_idx;
            end
        end
    end

    assign sel_valid  = sel_valid_q;
    assign sel_p2     = sel_p2_q;
    assign sel_strong = sel_strong_q;
    assign sel_idx    = sel_idx_q;
    assign ghr        = ghr_q;

endmodule

// File: tb/tb_cpht_choice_table.sv
// Directed, table-driven bench for cpht_choice_table at default parameters.
module tb_cpht_choice_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        sel_valid;
    logic        sel_p2;
    logic        sel_strong;
    logic [5:0]  sel_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_p1_res;
    logic        upd_p2_res;
    logic        ghr_push;
    logic        ghr_taken;
    logic        ghr_restore;
    logic [5:0]  ghr_restore_val;
    logic [5:0]  ghr;

    int checks = 0;
    int failures = 0;

    cpht_choice_table #(
        .ENTRIES(64), .IDX_W(6), .CTR_W(2), .GHR_W(6), .PC_W(32), .HASH_MODE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .sel_valid(sel_valid), .sel_p2(sel_p2), .sel_strong(sel_strong), .sel_idx(sel_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_p1_res(upd_p1_res), .upd_p2_res(upd_p2_res),
        .ghr_push(ghr_push), .ghr_taken(ghr_taken), .ghr_restore(ghr_restore),
        .ghr_restore_val(ghr_restore_val), .ghr(ghr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int uv; int ui; int p1; int p2;
        int lv; int li;
        int ev; int ep2; int es; int ei;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_of(input logic [5:0] i);
        return {24'd0, i, 2'b00};
    endfunction

    task automatic idle_inputs();
        lk_valid = 1'b0; lk_pc = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_p1_res = 1'b0; upd_p2_res = 1'b0;
        ghr_push = 1'b0; ghr_taken = 1'b0; ghr_restore = 1'b0; ghr_restore_val = '0;
    endtask

    task automatic sweep_all_zero(input string tag);
        for (int i = 0; i < 64; i++) begin
            lk_valid = 1'b1;
            lk_pc = pc_of(6'(i));
            cycle();
            check({tag, "_valid"}, int'(sel_valid), 1);
            check({tag, "_p2"}, int'(sel_p2), 0);
            check({tag, "_strong"}, int'(sel_strong), 1);
            check({tag, "_idx"}, int'(sel_idx), i);
        end
        lk_valid = 1'b0;
    endtask

    initial begin
        // uv ui p1 p2 | lv li | ev ep2 es ei
        vecs[0]  = '{0,0,0,0, 1,5, 1,0,1,5};
        vecs[1]  = '{1,5,0,1, 0,0, 0,0,1,5};
        vecs[2]  = '{0,0,0,0, 1,5, 1,0,0,5};
        vecs[3]  = '{1,5,0,1, 0,0, 0,0,0,5};
        vecs[4]  = '{0,0,0,0, 1,5, 1,1,0,5};
        vecs[5]  = '{1,5,0,1, 0,0, 0,1,0,5};
        vecs[6]  = '{0,0,0,0, 1,5, 1,1,1,5};
        vecs[7]  = '{1,5,0,1, 0,0, 0,1,1,5};
        vecs[8]  = '{0,0,0,0, 1,5, 1,1,1,5};
        vecs[9]  = '{1,5,1,1, 0,0, 0,1,1,5};
        vecs[10] = '{0,0,0,0, 1,5, 1,1,1,5};
        vecs[11] = '{1,5,0,0, 0,0, 0,1,1,5};
        vecs[12] = '{0,0,0,0, 1,5, 1,1,1,5};
        vecs[13] = '{1,5,1,0, 0,0, 0,1,1,5};
        vecs[14] = '{0,0,0,0, 1,5, 1,1,0,5};
        vecs[15] = '{1,5,1,0, 0,0, 0,1,0,5};
        vecs[16] = '{0,0,0,0, 1,5, 1,0,0,5};
        vecs[17] = '{1,5,1,0, 0,0, 0,0,0,5};
        vecs[18] = '{0,0,0,0, 1,5, 1,0,1,5};
        vecs[19] = '{1,5,1,0, 0,0, 0,0,1,5};
        vecs[20] = '{0,0,0,0, 1,5, 1,0,1,5};
        vecs[21] = '{1,9,0,1, 0,0, 0,0,1,5};
        vecs[22] = '{1,9,0,1, 1,9, 1,1,0,9};
        vecs[23] = '{1,5,1,0, 1,9, 1,1,0,9};
        vecs[24] = '{1,9,0,1, 1,9, 1,1,1,9};
        vecs[25] = '{0,0,0,0, 1,5, 1,0,1,5};

        idle_inputs();
        reset = 1'b1;
        #12;
        check("rst_valid", int'(sel_valid), 0);
        check("rst_p2", int'(sel_p2), 0);
        check("rst_strong", int'(sel_strong), 0);
        check("rst_idx", int'(sel_idx), 0);
        check("rst_ghr", int'(ghr), 0);
        #2;
        reset = 1'b0;
        cycle();

        sweep_all_zero("init");

        for (int n = 0; n < 26; n++) begin
            upd_valid  = vecs[n].uv[0];
            upd_idx    = vecs[n].ui[5:0];
            upd_p1_res = vecs[n].p1[0];
            upd_p2_res = vecs[n].p2[0];
            lk_valid   = vecs[n].lv[0];
            lk_pc      = pc_of(vecs[n].li[5:0]);
            cycle();
            check($sformatf("v%0d_valid", n), int'(sel_valid), vecs[n].ev);
            check($sformatf("v%0d_p2", n), int'(sel_p2), vecs[n].ep2);
            check($sformatf("v%0d_strong", n), int'(sel_strong), vecs[n].es);
            check($sformatf("v%0d_idx", n), int'(sel_idx), vecs[n].ei);
        end
        idle_inputs();
        check("ghr_untouched", int'(ghr), 0);

        // GHR pushes 1,0,1 then a lookup that must hash with the pre-push value
        ghr_push = 1'b1; ghr_taken = 1'b1; cycle();
        ghr_taken = 1'b0; cycle();
        ghr_taken = 1'b1; cycle();
        check("ghr_after_push", int'(ghr), 6'b000101);
        ghr_taken = 1'b0;
        lk_valid = 1'b1; lk_pc = 32'h40;
        cycle();
        check("hash_valid", int'(sel_valid), 1);
        check("hash_idx", int'(sel_idx), 21);
        check("hash_p2", int'(sel_p2), 0);
        check("ghr_push_with_lk", int'(ghr), 6'h0A);
        lk_valid = 1'b0;
        ghr_push = 1'b1; ghr_taken = 1'b1;
        ghr_restore = 1'b1; ghr_restore_val = 6'h2A;
        cycle();
        check("ghr_restore_prio", int'(ghr), 6'h2A);
        idle_inputs();
        cycle();
        check("ghr_hold", int'(ghr), 6'h2A);

        // Counter 9 sits at 3; index 9 under GHR 0x2A needs pc index 0x23
        lk_valid = 1'b1; lk_pc = pc_of(6'h23);
        cycle();
        check("pre_rst_valid", int'(sel_valid), 1);
        check("pre_rst_idx", int'(sel_idx), 9);
        check("pre_rst_p2", int'(sel_p2), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", int'(sel_valid), 0);
        check("async_p2", int'(sel_p2), 0);
        check("async_idx", int'(sel_idx), 0);
        check("async_ghr", int'(ghr), 0);
        @(negedge clk);
        reset = 1'b0;
        lk_valid = 1'b0;
        sweep_all_zero("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
